// File: rtl/approx_mult_error_evaluator.sv
// Sweep engine that drives every operand pair to an external approximate
// multiplier and accumulates error statistics against the exact product.
module approx_mult_error_evaluator #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAT  = 1,
  parameter int unsigned FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [W-1:0]          op_a,
  output logic [W-1:0]          op_b,
  input  logic [2*W-1:0]        approx_p,
  output logic                  busy,
  output logic                  done,
  output logic [2*W:0]          err_count,
  output logic [4*W-1:0]        sum_abs_err,
  output logic [2*W-1:0]        max_abs_err,
  output logic [4*W+FRAC-1:0]   sum_rel_err
);

  localparam int unsigned PW   = 2 * W;          // product width
  localparam int unsigned DW   = PW + FRAC;      // quotient width / divide cycles
  localparam int unsigned CNTW = PW + 1;         // error count width
  localparam int unsigned SW   = 4 * W;          // absolute error sum width
  localparam int unsigned RW   = 4 * W + FRAC;   // relative error sum width
  localparam int unsigned DCW  = $clog2(DW + 1); // divide step counter width
  localparam int unsigned WCW  = 4;              // wait counter width (LAT <= 15)

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_COMPARE,
    S_DIVIDE,
    S_ACCUM,
    S_FIN
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   idx;
  logic [WCW-1:0]  wait_cnt;
  logic [DCW-1:0]  div_cnt;
  logic [PW-1:0]   err_q;
  logic [PW-1:0]   exact_q;
  logic [PW-1:0]   rem;
  logic [DW-1:0]   quot;

  logic [PW-1:0]   exact_c;
  logic [PW-1:0]   err_c;
  logic [PW:0]     trial_c;
  logic            trial_ge_c;
  logic            last_c;

  // Exact product, absolute error and one restoring-divide step
  always_comb begin
    exact_c    = PW'(op_a) * PW'(op_b);
    err_c      = (approx_p >= exact_c) ? (approx_p - exact_c) : (exact_c - approx_p);
    trial_c    = {rem, quot[DW-1]};
    trial_ge_c = (trial_c >= {1'b0, exact_q});
    last_c     = (idx == {PW{1'b1}});
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_DRIVE;
      S_DRIVE:   state_nxt = (LAT > 1) ? S_WAIT : S_COMPARE;
      S_WAIT:    if (wait_cnt == WCW'(1)) state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = ((err_c == '0) || (exact_c == '0)) ? S_ACCUM : S_DIVIDE;
      S_DIVIDE:  if (div_cnt == DCW'(DW - 1)) state_nxt = S_ACCUM;
      S_ACCUM:   state_nxt = last_c ? S_FIN : S_DRIVE;
      S_FIN:     state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand drive, divider, statistics and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      sum_rel_err <= '0;
      idx         <= '0;
      wait_cnt    <= '0;
      div_cnt     <= '0;
      err_q       <= '0;
      exact_q     <= '0;
      rem         <= '0;
      quot        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            sum_rel_err <= '0;
            idx         <= '0;
            done        <= 1'b0;
            busy        <= 1'b1;
          end
        end
        S_DRIVE: begin
          op_a     <= idx[PW-1:W];
          op_b     <= idx[W-1:0];
          wait_cnt <= WCW'(LAT - 1);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - WCW'(1);
        end
        S_COMPARE: begin
          err_q   <= err_c;
          exact_q <= exact_c;
          rem     <= '0;
          div_cnt <= '0;
          // Quotient register starts holding the dividend; zero when no divide runs
          quot    <= ((err_c != '0) && (exact_c != '0)) ? (DW'(err_c) << FRAC) : '0;
        end
        S_DIVIDE: begin
          div_cnt <= div_cnt + DCW'(1);
          if (trial_ge_c) begin
            rem  <= PW'(trial_c - {1'b0, exact_q});
            quot <= {quot[DW-2:0], 1'b1};
          end else begin
            rem  <= trial_c[PW-1:0];
            quot <= {quot[DW-2:0], 1'b0};
          end
        end
        S_ACCUM: begin
          sum_abs_err <= sum_abs_err + SW'(err_q);
          sum_rel_err <= sum_rel_err + RW'(quot);
          err_count   <= err_count + CNTW'(err_q != '0);
          if (err_q > max_abs_err) max_abs_err <= err_q;
          if (!last_c) idx <= idx + PW'(1);
        end
        S_FIN: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mult_error_evaluator.sv
// Directed bench: two evaluators (LAT=1 and LAT=3) each beside a behavioural
// approximate multiplier whose error pattern is chosen per step.
module tb_approx_mult_error_evaluator;

  localparam int unsigned W    = 4;
  localparam int unsigned FRAC = 8;
  localparam int unsigned PW   = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, start, start3;
  logic [3:0]          mode;
  logic [W-1:0]        op_a, op_b, op_a3, op_b3;
  logic [PW-1:0]       approx_p, approx_p3, s1, s2;
  logic                busy, done, busy3, done3;
  logic [PW:0]         err_count, err_count3;
  logic [4*W-1:0]      sum_abs_err, sum_abs_err3;
  logic [PW-1:0]       max_abs_err, max_abs_err3;
  logic [4*W+FRAC-1:0] sum_rel_err, sum_rel_err3;

  int n_checks = 0;
  int n_fail   = 0;

  approx_mult_error_evaluator #(.W(W), .LAT(1), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .approx_p(approx_p), .busy(busy), .done(done), .err_count(err_count),
    .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .sum_rel_err(sum_rel_err)
  );

  approx_mult_error_evaluator #(.W(W), .LAT(3), .FRAC(FRAC)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_a(op_a3), .op_b(op_b3),
    .approx_p(approx_p3), .busy(busy3), .done(done3), .err_count(err_count3),
    .sum_abs_err(sum_abs_err3), .max_abs_err(max_abs_err3), .sum_rel_err(sum_rel_err3)
  );

  // Behavioural approximate multiplier, error pattern chosen by mode
  function automatic logic [PW-1:0] model(input logic [3:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b);
    case (m)
      4'd1:    return '0;
      4'd2:    return (a == 0 && b == 0) ? 8'd255 : p;
      4'd3:    return (a == 1 && b == 1) ? p + 8'd1 : p;
      4'd4:    return p & 8'hFE;
      default: return p;
    endcase
  endfunction

  // LAT=1: product valid in the cycle after the operands change
  assign approx_p = model(mode, op_a, op_b);

  // LAT=3: two extra register stages behind the multiply
  always @(posedge clk) begin
    s1 <= model(mode, op_a3, op_b3);
    s2 <= s1;
  end
  assign approx_p3 = s2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input bit use3, input int e_cnt,
                             input int e_sum, input int e_max, input int e_rel);
    if (use3) begin
      check({tag, "_done"}, 64'(done3), 64'd1);
      check({tag, "_cnt"},  64'(err_count3), 64'(e_cnt));
      check({tag, "_sum"},  64'(sum_abs_err3), 64'(e_sum));
      check({tag, "_max"},  64'(max_abs_err3), 64'(e_max));
      check({tag, "_rel"},  64'(sum_rel_err3), 64'(e_rel));
    end else begin
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_cnt"},  64'(err_count), 64'(e_cnt));
      check({tag, "_sum"},  64'(sum_abs_err), 64'(e_sum));
      check({tag, "_max"},  64'(max_abs_err), 64'(e_max));
      check({tag, "_rel"},  64'(sum_rel_err), 64'(e_rel));
    end
  endtask

  // Pulse start, optionally re-pulse at cycle extra_at, wait (bounded) for done
  task automatic sweep(input string tag, input bit use3, input int extra_at,
                       output int busy_cyc);
    int cyc;
    bit fin;
    busy_cyc = 0;
    cyc      = 0;
    fin      = 1'b0;
    @(negedge clk);
    if (use3) start3 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start3 = 1'b0;
    while (!fin && cyc < 20000) begin
      if (use3 ? busy3 : busy) busy_cyc++;
      if (use3 ? done3 : done) fin = 1'b1;
      else begin
        if (cyc == extra_at) begin
          if (use3) start3 = 1'b1; else start = 1'b1;
        end
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        cyc++;
      end
    end
    check({tag, "_finished"}, 64'(fin), 64'd1);
  endtask

  initial begin
    int bc;
    int e_rel;
    rst    = 1'b1;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 4'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cnt",  64'(err_count), 64'd0);
    check("rst_op_a", 64'(op_a), 64'd0);
    check("rst_rel",  64'(sum_rel_err), 64'd0);

    // Exact multiplier: no errors, busy 256*3+1 cycles
    mode = 4'd0;
    sweep("exact", 1'b0, -1, bc);
    check_stats("exact", 1'b0, 0, 0, 0, 0);
    check("exact_busy_cycles", 64'(bc), 64'd769);

    // Always-zero multiplier: every nonzero product is a full error
    mode = 4'd1;
    sweep("zero", 1'b0, -1, bc);
    check_stats("zero", 1'b0, 225, 14400, 225, 57600);

    // Error only where exact is zero: relative term skipped
    mode = 4'd2;
    sweep("zpair", 1'b0, -1, bc);
    check_stats("zpair", 1'b0, 1, 255, 255, 0);

    // Off-by-one at 1x1, LAT=1 and LAT=3
    mode = 4'd3;
    sweep("one", 1'b0, -1, bc);
    check_stats("one", 1'b0, 1, 1, 1, 256);
    sweep("one_lat3", 1'b1, -1, bc);
    check_stats("one_lat3", 1'b1, 1, 1, 1, 256);
    check("one_lat3_busy_cycles", 64'(bc), 64'(256 * 5 + 16 + 1));

    // Second start mid-sweep is ignored
    sweep("restart", 1'b0, 50, bc);
    check_stats("restart", 1'b0, 1, 1, 1, 256);
    check("restart_busy_cycles", 64'(bc), 64'(256 * 3 + 16 + 1));

    // Reset mid-sweep aborts and clears everything
    mode = 4'd1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    check("pre_rst_sum_nonzero", 64'(sum_abs_err != '0), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_cnt",  64'(err_count), 64'd0);
    check("mid_rst_sum",  64'(sum_abs_err), 64'd0);
    check("mid_rst_max",  64'(max_abs_err), 64'd0);
    check("mid_rst_rel",  64'(sum_rel_err), 64'd0);
    check("mid_rst_ops",  64'({op_a, op_b}), 64'd0);
    mode = 4'd3;
    sweep("after_rst", 1'b0, -1, bc);
    check_stats("after_rst", 1'b0, 1, 1, 1, 256);

    // LSB cleared: every odd product is off by one
    mode  = 4'd4;
    e_rel = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        if (((a * b) % 2) == 1) e_rel += 256 / (a * b);
    sweep("lsb", 1'b0, -1, bc);
    check_stats("lsb", 1'b0, 64, 64, 1, e_rel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/approx_mult_error_evaluator.md
Name: approx_mult_error_evaluator

Overview:
Hardware sweep engine that characterises an N-bit approximate multiplier on-chip or in simulation. It drives every operand pair to an external approximate multiplier and compares each returned product against an internally computed exact product. It accumulates error statistics (error count, summed/maximum absolute error, summed fixed-point relative error) so the mean error can be read out without a software loop. It sits beside the multiplier under evaluation in the approximate-multiplier characterisation harness.

Parameters:
W, 4, operand width; sweep covers 2^(2W) pairs.
LAT, 1, cycles from op_a/op_b update to valid approx_p (legal range 1..15).
FRAC, 8, fractional bits of the relative-error quotient.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a sweep
op_a  output  W  operand A to multiplier under test
op_b  output  W  operand B to multiplier under test
approx_p  input  2W  product returned by multiplier under test
busy  output  1  sweep in progress
done  output  1  sweep complete, statistics valid
err_count  output  2W+1  pairs with approx_p != exact
sum_abs_err  output  4W  sum of |approx_p - exact|
max_abs_err  output  2W  maximum |approx_p - exact|
sum_rel_err  output  4W+FRAC  sum of floor(|err| * 2^FRAC / exact) over pairs with exact != 0

Behaviour:
- Reset: FSM to IDLE; op_a, op_b, busy, done, and all statistics go to 0; pair index goes to 0. Reset mid-sweep aborts immediately with the same values.
- Sweep order: index i runs 0..2^(2W)-1; op_a = i[2W-1:W], op_b = i[W-1:0]. op_a/op_b are registered.
- FSM states: IDLE, DRIVE, WAIT, COMPARE, DIVIDE, ACCUM, FIN.
- IDLE: start=1 clears all statistics and index, clears done, sets busy, and moves to DRIVE. start while busy is ignored.
- DRIVE (1 cycle): loads op_a/op_b from index.
- WAIT: LAT-1 cycles. approx_p is sampled in COMPARE, which is exactly LAT cycles after the op registers update.
- COMPARE (1 cycle): exact = op_a*op_b (2W-bit unsigned); err = |approx_p - exact| with no wrap (unsigned compare, then subtract).
  - If err == 0: go to ACCUM.
  - If err != 0 and exact == 0: go to ACCUM, with a relative contribution of 0.
  - Otherwise: go to DIVIDE.
- DIVIDE: restoring divider, one quotient bit per cycle, exactly 2W+FRAC cycles. Quotient = floor((err << FRAC) / exact), width 2W+FRAC, no saturation needed.
- ACCUM (1 cycle):
  - sum_abs_err += err.
  - sum_rel_err += quotient.
  - err_count += (err != 0).
  - max_abs_err = max(max_abs_err, err).
  - If index is last: go to FIN; else index++ and go to DRIVE.
- FIN: busy=0, done=1, go to IDLE. done and all statistics hold until the next accepted start or rst.
- Accumulator widths are sized so that no overflow is possible. No wrap logic is required.
- Per-pair cycles = 1 + (LAT-1) + 1 + D + 1, where D = 2W+FRAC if a divide occurs, else 0. For an error-free run, busy is high for 2^(2W)*(LAT+2)+1 cycles.
- Mean relative error (%) = sum_rel_err * 100 / (2^FRAC * 2^(2W)). This is computed by the reader, averaging over all pairs including those with exact=0.
- Statistics outputs may change while busy. They are valid only when done=1.

Test Plan:
- W=4, FRAC=8, LAT=1, bench multiplier exact -> done=1; err_count=0, sum_abs_err=0, max_abs_err=0, sum_rel_err=0; busy high for 769 cycles.
- Bench multiplier always returns 0 -> err_count=225, sum_abs_err=14400, max_abs_err=225, sum_rel_err=57600 (225 x 256).
- Bench returns exact except 255 at a=0,b=0 -> err_count=1, sum_abs_err=255, max_abs_err=255, sum_rel_err=0 (zero-exact pair skipped).
- Bench returns exact+1 only at a=1,b=1 -> err_count=1, sum_abs_err=1, max_abs_err=1, sum_rel_err=256; repeat with LAT=3 and a 3-stage bench multiplier -> identical results.
- start pulsed again mid-sweep -> ignored, final results unchanged; rst asserted mid-sweep -> next cycle busy=0, done=0, all stats 0, op_a=op_b=0; a new start then completes normally.
- Exact product 8-bit check: bench returns exact with bit 0 cleared -> err_count=64, sum_abs_err=64, max_abs_err=1, sum_rel_err equal to the bench model's sum of floor(256/p) over odd p.
